// File: rtl/mult_pkg.sv
// Shared types for the shared shift-add multiplier scheduler: FSM states,
// operand width and iteration counter width, requester id.
package mult_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } sched_state_t;

  typedef logic req_id_t;
endpackage

// File: rtl/mult_scheduler_if.sv
// Two-requester job bus plus tagged product response; master = clients/consumer,
// slave = scheduler.
interface mult_scheduler_if;
  import mult_pkg::*;

  logic [1:0]            req_valid_i;
  logic [1:0][WIDTH-1:0] req_a_i;
  logic [1:0][WIDTH-1:0] req_b_i;
  logic [1:0]            req_ready_o;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  req_id_t               rsp_id_o;
  logic [2*WIDTH-1:0]    rsp_prod_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_prod_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_prod_o
  );
endinterface

// File: rtl/mult_datapath.sv
// Accumulator datapath {X,A,B} with S multiplicand and 9-bit adder/subtractor; one step per cycle.
// MULT_SCHED_SIGNED_EN selects two's-complement (sign-extended X) over unsigned (carry-out X).
module mult_datapath
  import mult_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               ld,
  input  logic               add_en,
  input  logic               sub,
  input  logic               shift_en,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               m,
  output logic [2*WIDTH-1:0] prod
);
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             x_q;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   sum;

`ifdef MULT_SCHED_SIGNED_EN
  assign a_ext = {a_q[WIDTH-1], a_q};
  assign s_ext = {s_q[WIDTH-1], s_q};
`else
  assign a_ext = {1'b0, a_q};
  assign s_ext = {1'b0, s_q};
`endif

  assign sum  = sub ? (a_ext - s_ext) : (a_ext + s_ext);
  assign m    = b_q[0];
  assign prod = {a_q, b_q};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s_q <= '0;
      a_q <= '0;
      b_q <= '0;
      x_q <= 1'b0;
    end else if (ld) begin
      s_q <= a_in;
      b_q <= b_in;
      a_q <= '0;
      x_q <= 1'b0;
    end else if (add_en) begin
      {x_q, a_q} <= sum;
    end else if (shift_en) begin
      a_q <= {x_q, a_q[WIDTH-1:1]};
      b_q <= {a_q[0], b_q[WIDTH-1:1]};
`ifndef MULT_SCHED_SIGNED_EN
      // Unsigned: the carry is consumed by the shift, so X empties.
      x_q <= 1'b0;
`endif
    end
  end
endmodule

// File: rtl/mult_scheduler.sv
// Round-robin two-port front end for the shared multiplier; product valid T+10+popcount(b) after accept.
// Requests wait unreadied while busy; DONE holds the response until rsp_ready_i. Build option: MULT_SCHED_SIGNED_EN.
module mult_scheduler
  import mult_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  mult_scheduler_if.slave  bus,
  output logic             busy_o
);
  sched_state_t       state_q;
  sched_state_t       state_d;
  req_id_t            last_grant_q;
  req_id_t            grant;
  req_id_t            id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               last_iter;
  logic               add_en;
  logic               sub;
  logic               shift_en;
  logic               m;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    if (bus.req_valid_i == 2'b11) grant = ~last_grant_q;
    else                          grant = ~bus.req_valid_i[0];
  end

  assign bus.req_ready_o = (state_q == IDLE) ?
                           (bus.req_valid_i & (grant ? 2'b10 : 2'b01)) : 2'b00;
  assign accept    = |bus.req_ready_o;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign sel_a     = bus.req_a_i[grant];
  assign sel_b     = bus.req_b_i[grant];

  // Operands are captured straight into S/B at the handshake, so LOAD can already see B[0].
  mult_datapath u_dp (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .ld       (accept),
    .add_en   (add_en),
    .sub      (sub),
    .shift_en (shift_en),
    .a_in     (sel_a),
    .b_in     (sel_b),
    .m        (m),
    .prod     (prod)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    add_en   = 1'b0;
    sub      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  state_d = m ? ADD : SHIFT;
      ADD: begin
        add_en  = 1'b1;
`ifdef MULT_SCHED_SIGNED_EN
        sub     = last_iter;
`endif
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        // prod[1] is B[1], which becomes B[0] after this shift.
        if (last_iter) state_d = DONE;
        else           state_d = prod[1] ? ADD : SHIFT;
      end
      DONE:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        last_grant_q <= grant;
        id_q         <= grant;
      end
      if (state_q == LOAD) cnt_q <= '0;
      else if (shift_en)   cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.rsp_valid_o = (state_q == DONE);
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_prod_o  = prod;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Shared 8x8 shift-add multiplier with a two-requester front end. Two client ports issue operand pairs through valid/ready handshakes. A round-robin arbiter grants one job at a time, and a sequencing FSM drives the embedded accumulator datapath through load, add/subtract and shift steps. Each 16-bit product is returned on a single response port tagged with the requester id. Sits between the switch/operand logic and the hex display path, replacing the single-user Run-driven control.

## Interface
- WIDTH, 8, operand width; product is 2*WIDTH; iteration count is WIDTH
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- req_valid_i  in  2  per-port job request
- req_a_i  in  2xWIDTH  per-port multiplicand S
- req_b_i  in  2xWIDTH  per-port multiplier B
- req_ready_o  out  2  per-port accept; at most one bit high
- rsp_valid_o  out  1  product available
- rsp_ready_i  in  1  consumer accepts product
- rsp_id_o  out  1  port that issued the job
- rsp_prod_o  out  2*WIDTH  product {A,B}
- busy_o  out  1  high in any state except IDLE

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE (enum in package).
- IDLE:
  - Arbiter picks a port when any req_valid_i is high.
  - req_ready_o[g] = IDLE & req_valid_i[g] & grant==g, combinational.
  - On handshake, latch operands and id, then go to LOAD.
- Round robin:
  - last_grant resets to 1, so port 0 wins the first tie.
  - When both ports are valid, grant !last_grant.
  - last_grant updates on each accept.
- LOAD: A<=0, X<=0, S<=a, B<=b, cnt<=0 → SHIFT if B[0]==0 else ADD.
- ADD:
  - A,X <= {S[7],S} + {A[7],A} as 9-bit.
  - On the last iteration (cnt==WIDTH-1), subtract instead (signed build).
  - Next state: SHIFT.
- SHIFT:
  - {X,A,B} arithmetic-shift right 1 (X replicated into MSB).
  - cnt++.
  - If cnt==WIDTH-1 → DONE; else next bit decides ADD or SHIFT (new B[0]).
- DONE:
  - rsp_valid_o=1; rsp_prod_o={A,B} and rsp_id_o held stable.
  - On rsp_ready_i → IDLE.
  - No new request is accepted in DONE or while busy.
- A pending request may drop req_valid_i before grant without error.
- Granted operands come from latched copies; later input changes are ignored.

## Timing
- Reset (async, immediate): state IDLE, all req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_prod_o=0, busy_o=0, last_grant=1.
- Latency, with acceptance in cycle T and k = number of ones in b:
  - LOAD at T+1.
  - rsp_valid_o first high at T+10+k (WIDTH=8); range 10..18 cycles.
- The earliest next accept is the cycle after the rsp handshake, since DONE → IDLE takes one cycle.
- Reset_n low mid-job: the job is discarded, no response is produced, and the pointer resets.
- rsp_ready_i high on DONE entry: single-cycle rsp_valid_o pulse.
- Both ports valid while busy: neither is readied; arbitration is evaluated again in IDLE.

## Configuration
- MULT_SCHED_SIGNED_EN defined:
  - Two's-complement operands.
  - Final-iteration ADD subtracts S.
  - X is the sign extension.
- MULT_SCHED_SIGNED_EN undefined:
  - Unsigned operands.
  - Every ADD adds.
  - X is the 9-bit carry out, and the shift is logical with X shifted into A[7].
- Latency is identical in both builds.

## Structure
- mult_pkg holds:
  - state enum sched_state_t
  - localparam WIDTH default and CNT_W = $clog2(WIDTH)
  - typedef req_id_t (1 bit)
- Sub-module mult_datapath holds:
  - S, A, B, X registers and the 9-bit adder/subtractor
  - control inputs ld, add_en, sub, shift_en
  - outputs M (=B[0]) and the product
- The top level holds the arbiter, FSM, counter and response register.

## Test plan
- Port 0, a=7, b=-3 (0xFD), signed → rsp_prod_o=0xFFEB, id 0, rsp_valid_o at T+17.
- Port 1, a=-128, b=-128 → 0x4000, id 1; a=5, b=0 → 0x0000 at T+10.
- Both ports valid continuously after reset → grants alternate 0,1,0,1; never two req_ready_o bits high.
- rsp_ready_i held low 5 cycles in DONE → product/id stable; req_ready_o stays 0 despite pending valid.
- Reset_n pulsed low at T+4 of a job → all outputs 0 immediately; no response; next tie grants port 0.
- Unsigned build: a=0xFF, b=0xFF → 0xFE01; a=0x80, b=0x02 → 0x0100.
